// File: rtl/mult_pkg.sv
// mult_pkg: shared types and constants for the sequential multiplier.
//   state_t       - controller states
//   DEFAULT_WIDTH - default operand width
//   COUNT_W       - iteration counter width for DEFAULT_WIDTH
package mult_pkg;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;
    localparam int DEFAULT_WIDTH = 64;
    localparam int COUNT_W = $clog2(DEFAULT_WIDTH);
endpackage

// File: rtl/twos_negate.sv
// twos_negate: two's-complement negation, out = ~in + 1.
//   in  - W-bit operand
//   out - W-bit negated result
module twos_negate #(
    parameter int W = 8
) (
    input  logic [W-1:0] in,
    output logic [W-1:0] out
);
    assign out = ~in + W'(1);
endmodule

// File: rtl/seq_multiplier.sv
// seq_multiplier: iterative shift-and-add multiplier, signed or unsigned, one bit per cycle.
//   clk       - system clock
//   reset     - asynchronous active-low reset
//   start     - request, sampled only in IDLE
//   is_signed - operands are two's-complement when 1, sampled with start
//   a, b      - WIDTH-bit operands, sampled with start
//   busy      - high in RUN and FINISH
//   done      - one-cycle strobe, product valid from this cycle on
//   product   - 2*WIDTH-bit result, held until the next done
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               is_signed,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic [WIDTH-1:0]   a_neg, b_neg;
    logic [2*WIDTH-1:0] p_neg;
    logic [WIDTH:0]     sum;

    twos_negate #(.W(WIDTH))   u_neg_a (.in(a), .out(a_neg));
    twos_negate #(.W(WIDTH))   u_neg_b (.in(b), .out(b_neg));
    twos_negate #(.W(2*WIDTH)) u_neg_p (.in({acc_q, mplier_q}), .out(p_neg));

    // Carry out of the add lands in the accumulator MSB after the shift.
    assign sum = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);

    always_comb begin
        state_d   = state_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        count_d   = count_q;
        neg_d     = neg_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            IDLE: if (start) begin
                mcand_d  = (is_signed && a[WIDTH-1]) ? a_neg : a;
                mplier_d = (is_signed && b[WIDTH-1]) ? b_neg : b;
                // A zero operand gives a zero product, so the sign fix is skipped.
                neg_d    = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]) && (a != '0) && (b != '0);
                acc_d    = '0;
                count_d  = '0;
                state_d  = RUN;
            end
            RUN: begin
                {acc_d, mplier_d} = {sum, mplier_q[WIDTH-1:1]};
                count_d = count_q + CW'(1);
                state_d = (count_q == CW'(WIDTH - 1)) ? FINISH : RUN;
            end
            FINISH: begin
                product_d = neg_q ? p_neg : {acc_q, mplier_q};
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            count_q   <= '0;
            neg_q     <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            neg_q     <= neg_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign product = product_q;
endmodule

// File: tb/tb_seq_multiplier.sv
// tb_seq_multiplier: randomized and directed checks of seq_multiplier against a timeline model.
module tb_seq_multiplier;
    localparam int W = 64;
    localparam int LAT = W + 2;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic           is_signed = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int vectors = 0;
    int errs = 0;

    seq_multiplier #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done), .product(product)
    );

    always #5 clk = ~clk;

    function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] xe, ye;
        xe = s ? {{W{x[W-1]}}, x} : {{W{1'b0}}, x};
        ye = s ? {{W{y[W-1]}}, y} : {{W{1'b0}}, y};
        return xe * ye;
    endfunction

    // Model: an accepted request produces its result W+1 edges later; requests while pending are dropped.
    int             left = 0;
    logic [2*W-1:0] pend = '0;
    logic [2*W-1:0] exp_prod = '0;
    logic           exp_done = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            left = 0;
            exp_prod = '0;
            exp_done = 1'b0;
        end else begin
            exp_done = 1'b0;
            if (left > 0) begin
                left--;
                if (left == 0) begin
                    exp_prod = pend;
                    exp_done = 1'b1;
                end
            end else if (start) begin
                pend = ref_mul(is_signed, a, b);
                left = W + 1;
            end
        end
    end

    task automatic chk(input string n, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        vectors++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h want %h", n, act, req);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", (2*W)'(busy), (2*W)'(left > 0));
        chk("done", (2*W)'(done), (2*W)'(exp_done));
        chk("product", product, exp_prod);
    end

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 200);
    endtask

    task automatic op(input logic s, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic [2*W-1:0] lit, input bit pin, input string n);
        int c;
        @(negedge clk);
        is_signed = s; a = x; b = y; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        is_signed = ~s;
        wait_done(c);
        chk({n, " latency"}, (2*W)'(c + 1), (2*W)'(LAT));
        chk({n, " result"}, product, lit);
        if (pin) chk({n, " model"}, ref_mul(s, x, y), lit);
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return {1'b1, {(W-1){1'b0}}};
            2: return '1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        int c;
        logic s;
        logic [W-1:0] x, y;
        repeat (3) @(negedge clk);
        chk("reset busy", (2*W)'(busy), '0);
        chk("reset product", product, '0);
        #2 reset = 1'b1;

        op(1'b0, 64'd3, 64'd5, 128'd15, 1, "u3x5");
        op(1'b0, '1, '1, {64'hFFFF_FFFF_FFFF_FFFE, 64'h1}, 1, "umax");
        op(1'b1, '1, '1, 128'd1, 1, "s-1x-1");
        op(1'b1, -64'sd7, 64'd6, {{W{1'b1}}, 64'hFFFF_FFFF_FFFF_FFD6}, 1, "s-7x6");
        op(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, {64'h4000_0000_0000_0000, 64'h0}, 1, "sminsq");
        op(1'b1, '0, -64'sd5, '0, 1, "szero");

        @(negedge clk);
        is_signed = 1'b0; a = 64'd5; b = 64'd7; start = 1'b1;
        @(negedge clk);
        a = 64'd9; b = 64'd9;
        repeat (30) @(negedge clk);
        start = 1'b0;
        wait_done(c);
        chk("held start latency", (2*W)'(c + 31), (2*W)'(LAT));
        chk("held start result", product, 128'd35);

        @(negedge clk);
        is_signed = 1'b0; a = 64'd2; b = 64'd4; start = 1'b1;
        wait_done(c);
        chk("b2b first latency", (2*W)'(c), (2*W)'(LAT));
        chk("b2b first result", product, 128'd8);
        wait_done(c);
        chk("b2b interval", (2*W)'(c), (2*W)'(LAT));
        chk("b2b second result", product, 128'd8);
        start = 1'b0;
        c = 0;
        while (busy && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("b2b drain", (2*W)'(busy), '0);

        @(negedge clk);
        a = 64'd100; b = 64'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async rst busy", (2*W)'(busy), '0);
        chk("async rst done", (2*W)'(done), '0);
        chk("async rst product", product, '0);
        @(negedge clk);
        @(negedge clk);
        #2 reset = 1'b1;
        op(1'b0, 64'd2, 64'd3, 128'd6, 1, "after reset");

        for (int i = 0; i < 16; i++) begin
            s = 1'($urandom);
            x = pick();
            y = pick();
            op(s, x, y, ref_mul(s, x, y), 0, "random");
        end

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
